// File: rtl/rsc_mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rsc_mem_pkg : shared types and default widths for rsc_mem_ctrl     |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
package rsc_mem_pkg;

  localparam int c_def_addr_w = 16;
  localparam int c_def_data_w = 16;
  localparam int c_cnt_w      = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rsc_sram.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rsc_sram : single-port synchronous RAM, 1-cycle registered read    |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module rsc_sram
  import rsc_mem_pkg::*;
#(
  parameter int DATA_W     = c_def_data_w,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [DATA_W-1:0]     din,
  output logic [DATA_W-1:0]     dout
);

  logic [DATA_W-1:0] r_mem [0:(1<<DEPTH_LOG2)-1];

  // Read-before-write on a shared index: dout shows the old word.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[idx] <= din;
    end
    dout <= r_mem[idx];
  end

endmodule
`default_nettype wire

// File: rtl/rsc_mem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rsc_mem_ctrl : req/ack memory controller with wait states.         |
// | Optional RSC_MEM_BOUNDS_CHECK_EN flags out-of-range addresses.     |
// | Revision     : 1.0                                                 |
// +--------------------------------------------------------------------+
module rsc_mem_ctrl
  import rsc_mem_pkg::*;
#(
  parameter int ADDR_W      = c_def_addr_w,
  parameter int DATA_W      = c_def_data_w,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              busy,
  output logic              err
);

  localparam logic [c_cnt_w-1:0] c_wait_load = c_cnt_w'(WAIT_CYCLES);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [c_cnt_w-1:0]    r_cnt;
  logic                  r_we;
  logic                  r_oob;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W-1:0]     r_rdata;
  logic [DATA_W-1:0]     w_dout;
  logic [DATA_W-1:0]     w_rd_val;
  logic                  w_oob;
  logic                  w_ram_we;

`ifdef RSC_MEM_BOUNDS_CHECK_EN
  assign w_oob = |addr[ADDR_W-1:DEPTH_LOG2];
`else
  logic w_unused_hi;
  assign w_unused_hi = ^addr[ADDR_W-1:DEPTH_LOG2];
  assign w_oob       = 1'b0;
`endif

  assign w_ram_we = (r_state == ACCESS) && r_we && !r_oob;
  assign w_rd_val = r_oob ? '0 : w_dout;

  rsc_sram #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_sram (
    .clk  (clk),
    .we   (w_ram_we),
    .idx  (r_idx),
    .din  (r_wdata),
    .dout (w_dout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_oob   <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req) begin
            r_cnt   <= c_wait_load;
            r_we    <= we;
            r_oob   <= w_oob;
            r_idx   <= addr[DEPTH_LOG2-1:0];
            r_wdata <= wdata;
          end
        end
        WAIT:    r_cnt <= r_cnt - 1'b1;
        DONE: begin
          if (!r_we) begin
            r_rdata <= w_rd_val;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    ack         = 1'b0;
    busy        = (r_state != IDLE);
    err         = 1'b0;
    // The RAM's registered output is live during DONE, so reads expose it
    // directly that cycle and the holding register takes over afterwards.
    rdata       = r_rdata;
    case (r_state)
      IDLE: begin
        if (req) begin
          w_state_nxt = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == c_cnt_w'(1)) begin
          w_state_nxt = ACCESS;
        end
      end
      ACCESS:  w_state_nxt = DONE;
      DONE: begin
        w_state_nxt = IDLE;
        ack         = 1'b1;
`ifdef RSC_MEM_BOUNDS_CHECK_EN
        err         = r_oob;
`endif
        if (!r_we) begin
          rdata = w_rd_val;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_rsc_mem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_rsc_mem_ctrl : self-checking bench, WAIT_CYCLES=2 and =0 DUTs   |
// | Revision        : 1.0                                              |
// +--------------------------------------------------------------------+
module tb_rsc_mem_ctrl;

`ifdef RSC_MEM_BOUNDS_CHECK_EN
  localparam bit c_bounds = 1'b1;
`else
  localparam bit c_bounds = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, we0 = 1'b0;
  logic [15:0] addr0 = '0, wdata0 = '0;
  logic [15:0] rdata0;
  logic        ack0, busy0, err0;
  logic        req1 = 1'b0, we1 = 1'b0;
  logic [15:0] addr1 = '0, wdata1 = '0;
  logic [15:0] rdata1;
  logic        ack1, busy1, err1;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem_m [int];

  always #5 clk = ~clk;

  rsc_mem_ctrl #(.ADDR_W(16), .DATA_W(16), .DEPTH_LOG2(10), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata0), .ack(ack0), .busy(busy0), .err(err0)
  );

  rsc_mem_ctrl #(.ADDR_W(16), .DATA_W(16), .DEPTH_LOG2(10), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
    .rdata(rdata1), .ack(ack1), .busy(busy1), .err(err1)
  );

  task automatic txn0(input logic w, input logic [15:0] a, input logic [15:0] d,
                      output int lat, output logic [15:0] rd, output logic e);
    int guard = 0;
    @(negedge clk);
    while (busy0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
    @(posedge clk); #1;
    req0 = 1'b0; we0 = 1'($urandom); addr0 = 16'($urandom); wdata0 = 16'($urandom);
    lat = 0; rd = '0; e = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (ack0) begin
        lat = k; rd = rdata0; e = err0;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic txn1(input logic w, input logic [15:0] a, input logic [15:0] d,
                      output int lat, output logic [15:0] rd);
    int guard = 0;
    @(negedge clk);
    while (busy1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
    @(posedge clk); #1;
    req1 = 1'b0;
    lat = 0; rd = '0;
    for (int k = 1; k <= 20; k++) begin
      if (ack1) begin
        lat = k; rd = rdata1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rdata0 !== 16'h0000) begin errors++; $display("FAIL reset_rdata: got %h want 0000", rdata0); end
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", ack0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy0); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err0); end
    checks++; if ({ack1, busy1, err1} !== 3'b000) begin errors++; $display("FAIL reset_dut1: got %b want 000", {ack1, busy1, err1}); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    int lat; logic [15:0] rd; logic e;
    txn0(1'b1, 16'h0012, 16'hBEEF, lat, rd, e);
    mem_m[12'h012] = 16'hBEEF;
    checks++; if (lat !== 4) begin errors++; $display("FAIL wr_latency: got %0d want 4", lat); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL wr_err: got %b want 0", e); end
    @(posedge clk); #1;
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL busy_fall: got %b want 0", busy0); end
    txn0(1'b0, 16'h0012, 16'h0000, lat, rd, e);
    checks++; if (lat !== 4) begin errors++; $display("FAIL rd_latency: got %0d want 4", lat); end
    checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL rd_data: got %h want BEEF", rd); end
    txn0(1'b1, 16'h0013, 16'h1234, lat, rd, e);
    mem_m[12'h013] = 16'h1234;
    checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL rdata_after_wr: got %h want BEEF", rd); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rdata0 !== 16'hBEEF) begin errors++; $display("FAIL rdata_hold: got %h want BEEF", rdata0); end
  endtask

  task automatic test_back_to_back();
    int t[2]; logic [15:0] r[2]; int n = 0; int guard = 0;
    t[0] = 0; t[1] = 0; r[0] = '0; r[1] = '0;
    @(negedge clk);
    while (busy0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0012;
    for (int c = 1; c <= 20 && n < 2; c++) begin
      @(posedge clk); #1;
      if (c <= 3) addr0 = 16'($urandom);
      if (c == 1) begin
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL b2b_busy_rise: got %b want 1", busy0); end
      end
      if (ack0) begin
        t[n] = c; r[n] = rdata0; n++;
        if (n == 1) addr0 = 16'h0013;
        else req0 = 1'b0;
      end
    end
    req0 = 1'b0;
    checks++; if (n !== 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", n); end
    checks++; if (t[0] !== 4) begin errors++; $display("FAIL b2b_first_ack: got %0d want 4", t[0]); end
    checks++; if (t[1] - t[0] !== 5) begin errors++; $display("FAIL b2b_interval: got %0d want 5", t[1] - t[0]); end
    checks++; if (r[0] !== mem_m[12'h012]) begin errors++; $display("FAIL b2b_rd0: got %h want %h", r[0], mem_m[12'h012]); end
    checks++; if (r[1] !== mem_m[12'h013]) begin errors++; $display("FAIL b2b_rd1: got %h want %h", r[1], mem_m[12'h013]); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [15:0] rd; logic e; int guard = 0; bit seen = 1'b0;
    txn0(1'b1, 16'h0020, 16'h0F0F, lat, rd, e);
    mem_m[12'h020] = 16'h0F0F;
    @(negedge clk);
    while (busy0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0020; wdata0 = 16'hAAAA;
    @(posedge clk); #1;
    req0 = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy0); end
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (ack0) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_ack: got %b want 0", seen); end
    txn0(1'b0, 16'h0020, 16'h0000, lat, rd, e);
    checks++; if (rd !== 16'h0F0F) begin errors++; $display("FAIL rstmid_data: got %h want 0F0F", rd); end
  endtask

  task automatic test_wait0();
    int lat; logic [15:0] rd;
    txn1(1'b1, 16'h0012, 16'hBEEF, lat, rd);
    checks++; if (lat !== 2) begin errors++; $display("FAIL w0_wr_latency: got %0d want 2", lat); end
    txn1(1'b0, 16'h0012, 16'h0000, lat, rd);
    checks++; if (lat !== 2) begin errors++; $display("FAIL w0_rd_latency: got %0d want 2", lat); end
    checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL w0_rd_data: got %h want BEEF", rd); end
  endtask

  task automatic test_bounds();
    int lat; logic [15:0] rd; logic e; logic [15:0] exp;
    txn0(1'b1, 16'h0412, 16'h5555, lat, rd, e);
    if (!c_bounds) mem_m[12'h012] = 16'h5555;
    checks++; if (lat !== 4) begin errors++; $display("FAIL oob_latency: got %0d want 4", lat); end
    checks++; if (e !== c_bounds) begin errors++; $display("FAIL oob_wr_err: got %b want %b", e, c_bounds); end
    txn0(1'b0, 16'h0012, 16'h0000, lat, rd, e);
    exp = c_bounds ? 16'hBEEF : 16'h5555;
    checks++; if (rd !== exp) begin errors++; $display("FAIL oob_rd_data: got %h want %h", rd, exp); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL inrange_err: got %b want 0", e); end
    txn0(1'b0, 16'h0412, 16'h0000, lat, rd, e);
    exp = c_bounds ? 16'h0000 : 16'h5555;
    checks++; if (rd !== exp) begin errors++; $display("FAIL oob_rd_zero: got %h want %h", rd, exp); end
    checks++; if (e !== c_bounds) begin errors++; $display("FAIL oob_rd_err: got %b want %b", e, c_bounds); end
  endtask

  task automatic test_random();
    int lat; logic [15:0] rd; logic e;
    logic [15:0] a, d, exp_rd = '0;
    bit w, oob, have_rd = 1'b0;
    int idx;
    for (int i = 0; i < 8; i++) begin
      d = 16'($urandom);
      txn0(1'b1, 16'h0040 + 16'(i), d, lat, rd, e);
      mem_m[16'h40 + i] = d;
    end
    for (int i = 0; i < 40; i++) begin
      idx = 'h40 + int'($urandom_range(0, 7));
      a = ($urandom_range(0, 3) == 0) ? 16'({6'($urandom), 10'(idx)}) : 16'(idx);
      w = 1'($urandom);
      d = 16'($urandom);
      oob = c_bounds && (a[15:10] != 6'd0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      txn0(w, a, d, lat, rd, e);
      checks++; if (lat !== 4) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d want 4", i, lat); end
      checks++; if (e !== oob) begin errors++; $display("FAIL rnd_err[%0d]: got %b want %b", i, e, oob); end
      if (w) begin
        if (!oob) mem_m[idx] = d;
        if (have_rd) begin
          checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rnd_wr_rdata[%0d]: got %h want %h", i, rd, exp_rd); end
        end
      end else begin
        exp_rd = oob ? 16'h0000 : mem_m[idx];
        have_rd = 1'b1;
        checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rnd_rd_data[%0d]: got %h want %h", i, rd, exp_rd); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_reset_mid();
    test_wait0();
    test_bounds();
    test_random();
    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
